// File: rtl/uctl_token_tx_pkg.sv
// Shared definitions for the USB token transmit path: CRC5 constants,
// FSM encoding, PID codes and the captured token payload.
package uctl_token_tx_pkg;

    localparam int unsigned CRC_W  = 5;
    localparam int unsigned PID_W  = 4;
    localparam int unsigned TOK_W  = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;
    localparam logic [CRC_W-1:0] CRC5_INIT = 5'b11111;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOK_W - 1);

    localparam logic [PID_W-1:0] PID_OUT   = 4'h1;
    localparam logic [PID_W-1:0] PID_IN    = 4'h9;
    localparam logic [PID_W-1:0] PID_SOF   = 4'h5;
    localparam logic [PID_W-1:0] PID_SETUP = 4'hD;
    localparam logic [PID_W-1:0] PID_PING  = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SEND_PID,
        ST_SEND_B1,
        ST_SEND_B2
    } state_e;

    typedef struct packed {
        logic [PID_W-1:0] pid;
        logic [TOK_W-1:0] data;
    } token_t;

    // One serial LFSR step, data bit applied against the MSB feedback.
    function automatic logic [CRC_W-1:0] crc5_next(input logic [CRC_W-1:0] c, input logic d);
        logic fb;
        fb = d ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : CRC_W'(0));
    endfunction

    // Transmitted CRC field: inverted register, bit-reversed.
    function automatic logic [CRC_W-1:0] crc5_field(input logic [CRC_W-1:0] c);
        return {~c[0], ~c[1], ~c[2], ~c[3], ~c[4]};
    endfunction

endpackage

// File: rtl/uctl_crc5_serial.sv
// Serial CRC5 LFSR: one bit per cycle when shift is high, reseeded by init.
module uctl_crc5_serial
    import uctl_token_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             shift,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC5_INIT;
        end else if (shift) begin
            crc_d = crc5_next(crc_q, din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC5_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/uctl_token_tx.sv
// Token packet generator: captures PID/token field, runs CRC5 over the
// 11 field bits, then streams PID, byte1, byte2 over valid/ready.
module uctl_token_tx
    import uctl_token_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_start,
    input  logic [PID_W-1:0]  tok_pid,
    input  logic [TOK_W-1:0]  tok_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              tok_busy,
    output logic              tok_done,
    output logic [CRC_W-1:0]  crc5_out
);

    state_e            state_q, state_d;
    token_t            tok_q, tok_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_last_q, tx_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CRC_W-1:0]  crc5_q, crc5_d;

    logic              crc_init_c;
    logic              crc_shift_c;
    logic              crc_din_c;
    logic [CRC_W-1:0]  crc_w;

    uctl_crc5_serial u_crc5 (
        .clk   (clk),
        .rst   (rst),
        .init  (crc_init_c),
        .shift (crc_shift_c),
        .din   (crc_din_c),
        .crc   (crc_w)
    );

    always_comb begin
        state_d     = state_q;
        tok_d       = tok_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        crc5_d      = crc5_q;
        crc_init_c  = 1'b0;
        crc_shift_c = 1'b0;
        crc_din_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tok_start) begin
                    tok_d.pid  = tok_pid;
                    tok_d.data = tok_data;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    crc_init_c = 1'b1;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                crc_shift_c = 1'b1;
                crc_din_c   = tok_q.data[cnt_q];
                if (cnt_q == CNT_LAST) begin
                    // The LFSR only takes its last bit on this edge, so the
                    // field is derived from the look-ahead value.
                    crc5_d     = crc5_field(crc5_next(crc_w, crc_din_c));
                    tx_data_d  = {~tok_q.pid, tok_q.pid};
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    state_d    = ST_SEND_PID;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND_PID: begin
                if (tx_ready) begin
                    tx_data_d = tok_q.data[7:0];
                    state_d   = ST_SEND_B1;
                end
            end
            ST_SEND_B1: begin
                if (tx_ready) begin
                    tx_data_d = {crc5_q, tok_q.data[TOK_W-1:8]};
                    tx_last_d = 1'b1;
                    state_d   = ST_SEND_B2;
                end
            end
            ST_SEND_B2: begin
                if (tx_ready) begin
                    tx_data_d  = '0;
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    crc5_d     = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tok_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc5_q     <= '0;
        end else begin
            state_q    <= state_d;
            tok_q      <= tok_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc5_q     <= crc5_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign tok_busy = busy_q;
    assign tok_done = done_q;
    assign crc5_out = crc5_q;

endmodule

// File: tb/tb_uctl_token_tx.sv
// Randomized self-checking bench for uctl_token_tx against a transaction-level
// timeline model (latency, byte queue, busy/done flags) built from the token format.
module tb_uctl_token_tx;

    logic        clk;
    logic        rst;
    logic        tok_start;
    logic [3:0]  tok_pid;
    logic [10:0] tok_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        tok_busy;
    logic        tok_done;
    logic [4:0]  crc5_out;

    int n_chk;
    int n_fail;

    uctl_token_tx dut (
        .clk       (clk),
        .rst       (rst),
        .tok_start (tok_start),
        .tok_pid   (tok_pid),
        .tok_data  (tok_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .tok_busy  (tok_busy),
        .tok_done  (tok_done),
        .crc5_out  (crc5_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run an LFSR over n bits of a stream, LSB first.
    function automatic logic [4:0] lfsr_run(input logic [15:0] bits, input int n);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < n; i++) begin
            fb = bits[i] ^ c[4];
            c  = 5'((c << 1) ^ (fb ? 5'h05 : 5'h00));
        end
        return c;
    endfunction

    function automatic logic [4:0] model_crc(input logic [10:0] d);
        logic [4:0] c;
        logic [4:0] f;
        c = lfsr_run({5'h0, d}, 11);
        for (int i = 0; i < 5; i++) f[4-i] = ~c[i];
        return f;
    endfunction

    // ---------------- timeline model + compare ----------------
    logic       m_busy;
    logic       m_done;
    int         m_wait;
    logic [4:0] m_crc;
    logic [7:0] m_bytes[$];
    logic [7:0] xlog[$];

    initial begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_wait = 0;
        m_crc  = 5'h0;
    end

    always @(negedge clk) begin
        logic       exp_valid;
        logic       nxt_done;
        logic [4:0] c;
        exp_valid = m_busy && (m_wait == 0) && (m_bytes.size() != 0);
        chk("tok_busy", 32'(tok_busy), 32'(m_busy));
        chk("tok_done", 32'(tok_done), 32'(m_done));
        chk("tx_valid", 32'(tx_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("tx_data", 32'(tx_data), 32'(m_bytes[0]));
            chk("tx_last", 32'(tx_last), 32'(m_bytes.size() == 1));
            chk("crc5_out", 32'(crc5_out), 32'(m_crc));
        end
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_wait = 0;
            m_crc  = 5'h0;
            m_bytes.delete();
        end else begin
            if (tx_valid && tx_ready) xlog.push_back(tx_data);
            nxt_done = 1'b0;
            if (m_busy) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else if (tx_ready) begin
                    void'(m_bytes.pop_front());
                    if (m_bytes.size() == 0) begin
                        m_busy   = 1'b0;
                        nxt_done = 1'b1;
                    end
                end
            end else if (tok_start) begin
                c = model_crc(tok_data);
                m_busy = 1'b1;
                m_wait = 11;
                m_crc  = c;
                m_bytes.delete();
                m_bytes.push_back({~tok_pid, tok_pid});
                m_bytes.push_back(tok_data[7:0]);
                m_bytes.push_back({c, tok_data[10:8]});
            end
            m_done = nxt_done;
        end
    end

    // ---------------- ready generator ----------------
    int ready_mode;   // 0: always ready, 1: 3-cycle stall per byte, 2: random
    int stall_cnt;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            tx_ready = 1'b1;
        end else if (ready_mode == 1) begin
            if (tx_valid && stall_cnt < 3) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready = 1'b1;
                if (tx_valid) stall_cnt = 0;
            end
        end else begin
            tx_ready = ($urandom_range(3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_pkt(input logic [3:0] p, input logic [10:0] d);
        tok_start = 1'b1;
        tok_pid   = p;
        tok_data  = d;
        cyc(1);
        tok_start = 1'b0;
        tok_pid   = 4'($urandom);
        tok_data  = 11'($urandom);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 400; i++) begin
            if (tok_done) break;
            cyc(1);
        end
        if (i == 400) chk("done_timeout", 32'(1), 32'(0));
    endtask

    task automatic chk_log3(input string name, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        chk({name, "_count"}, 32'(xlog.size()), 32'(3));
        if (xlog.size() == 3) begin
            chk({name, "_b0"}, 32'(xlog[0]), 32'(b0));
            chk({name, "_b1"}, 32'(xlog[1]), 32'(b1));
            chk({name, "_b2"}, 32'(xlog[2]), 32'(b2));
        end
    endtask

    initial begin
        logic [3:0]  p;
        logic [10:0] d;
        n_chk      = 0;
        n_fail     = 0;
        ready_mode = 0;
        stall_cnt  = 0;
        rst        = 1'b1;
        tok_start  = 1'b0;
        tok_pid    = 4'h0;
        tok_data   = 11'h0;
        tx_ready   = 1'b1;
        cyc(3);
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_crc5", 32'(crc5_out), 32'(0));
        chk("rst_tx_last", 32'(tx_last), 32'(0));
        rst = 1'b0;
        cyc(2);

        // model pins against hand-computed values
        chk("model_crc_setup", 32'(model_crc(11'h000)), 32'h02);
        chk("model_crc_out", 32'(model_crc(11'h001)), 32'h1D);

        // SETUP addr0 ep0
        xlog.delete();
        start_pkt(4'hD, 11'h000);
        cyc(10);
        chk("latency_not_yet", 32'(tx_valid), 32'(0));
        cyc(1);
        chk("latency_pid", 32'(tx_valid), 32'(1));
        chk("setup_crc5", 32'(crc5_out), 32'h02);
        wait_done();
        chk_log3("setup", 8'h2D, 8'h00, 8'h10);
        cyc(1);
        chk("done_one_cycle", 32'(tok_done), 32'(0));

        // OUT addr1 ep0
        xlog.delete();
        start_pkt(4'h1, 11'h001);
        cyc(11);
        chk("out_crc5", 32'(crc5_out), 32'h1D);
        wait_done();
        chk_log3("out", 8'hE1, 8'h01, 8'hE8);

        // backpressure: 3 stall cycles on every byte
        ready_mode = 1;
        stall_cnt  = 0;
        xlog.delete();
        start_pkt(4'hD, 11'h000);
        wait_done();
        chk_log3("stall", 8'h2D, 8'h00, 8'h10);
        ready_mode = 0;
        cyc(2);

        // starts while busy are ignored; start in the done cycle is taken
        xlog.delete();
        start_pkt(4'h9, 11'h155);
        cyc(3);
        start_pkt(4'h5, 11'h7FF);     // during CALC
        cyc(8);
        start_pkt(4'h4, 11'h2AA);     // during SEND_B1
        wait_done();
        start_pkt(4'h1, 11'h0F0);
        wait_done();
        chk("busy_start_count", 32'(xlog.size()), 32'(6));
        if (xlog.size() == 6) begin
            chk("busy_first_pid", 32'(xlog[0]), 32'h69);
            chk("busy_first_b1", 32'(xlog[1]), 32'h55);
            chk("busy_second_pid", 32'(xlog[3]), 32'hE1);
            chk("busy_second_b1", 32'(xlog[4]), 32'hF0);
        end
        cyc(2);

        // reset during SEND_B1
        xlog.delete();
        start_pkt(4'hD, 11'h3C5);
        cyc(12);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_valid", 32'(tx_valid), 32'(0));
        chk("midrst_data", 32'(tx_data), 32'(0));
        chk("midrst_busy", 32'(tok_busy), 32'(0));
        chk("midrst_crc5", 32'(crc5_out), 32'(0));
        cyc(1);
        chk("midrst_no_done", 32'(tok_done), 32'(0));
        xlog.delete();
        start_pkt(4'hD, 11'h000);
        wait_done();
        chk_log3("after_rst", 8'h2D, 8'h00, 8'h10);

        // random packets with random backpressure
        ready_mode = 2;
        for (int k = 0; k < 500; k++) begin
            p = 4'($urandom);
            d = 11'($urandom);
            xlog.delete();
            start_pkt(p, d);
            wait_done();
            chk("rnd_count", 32'(xlog.size()), 32'(3));
            if (xlog.size() == 3) begin
                chk("rnd_residual", 32'(lfsr_run({xlog[2][7:3], d}, 16)), 32'h0C);
            end
            if ($urandom_range(1) == 0) cyc(1);
        end
        ready_mode = 0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
